// File: rtl/codec_intf_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : codec_intf_if
//  Brief    : Sample bus between the codec serial interface and the
//             equalizer core (received samples out, processed samples in).
//  Revision : 1.0  initial release
// ============================================================================
interface codec_intf_if;
  logic [15:0] lft_in;   // deserialized left sample to core
  logic [15:0] rht_in;   // deserialized right sample to core
  logic        valid;    // one-cycle new-sample pulse
  logic [15:0] lft_out;  // processed left sample from core
  logic [15:0] rht_out;  // processed right sample from core

  // Codec-side view: produces received samples, consumes processed ones.
  modport master (
    output lft_in,
    output rht_in,
    output valid,
    input  lft_out,
    input  rht_out
  );

  // Core-side view.
  modport slave (
    input  lft_in,
    input  rht_in,
    input  valid,
    output lft_out,
    output rht_out
  );
endinterface
`default_nettype wire

// File: rtl/codec_intf.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : codec_intf
//  Brief    : I2S codec interface. Generates MCLK/SCLK/LRCLK from a 10-bit
//             frame counter, deserializes 16-bit left/right ADC samples and
//             serializes 16-bit left/right DAC samples.
//  Revision : 1.0  initial release
// ============================================================================
module codec_intf (
  input  wire logic     clk,
  input  wire logic     rst_n,
  input  wire logic     SDin,
  output logic          SDout,
  output logic          LRCLK,
  output logic          SCLK,
  output logic          MCLK,
  output logic          RSTn,
  codec_intf_if.master  core
);

  // Counter landmarks. A frame is left half (cnt[9]=1) then right half.
  localparam logic [9:0] c_cnt_reset   = 10'h200;  // start of a left half
  localparam logic [9:0] c_cnt_max     = 10'h3FF;  // codec leaves reset after this
  localparam logic [9:0] c_cnt_arm     = 10'h1FF;  // last cycle before a left half
  localparam logic [9:0] c_cnt_last_rx = 10'h107;  // rise event of last right bit

  logic [9:0]  r_cnt;
  logic        r_rstn;
  logic        r_armed;
  logic [15:0] r_sh_l;
  logic [15:0] r_sh_r;
  logic [15:0] r_lft_in;
  logic [15:0] r_rht_in;
  logic        r_valid;
  logic [15:0] r_hold_l;
  logic [15:0] r_hold_r;
  logic        r_sdout;

  logic [4:0]  w_slot;
  logic        w_rise;
  logic        w_fall;
  logic        w_rx_slot;
  logic        w_tx_slot;
  logic [3:0]  w_bit_idx;
  logic        w_tx_bit;

  // Bit slot within the half-frame and the SCLK-aligned sampling/launch events.
  assign w_slot    = r_cnt[8:4];
  assign w_rise    = (r_cnt[3:0] == 4'h7);
  assign w_fall    = (r_cnt[3:0] == 4'hF);
  // One-bit I2S delay: data bits occupy slots 1..16 at the receiver, and are
  // launched one slot earlier (slots 0..15) by the transmitter.
  assign w_rx_slot = (w_slot != 5'd0) && (w_slot <= 5'd16);
  assign w_tx_slot = ~w_slot[4];
  assign w_bit_idx = ~w_slot[3:0];  // 15 - slot: MSB first
  assign w_tx_bit  = r_cnt[9] ? r_hold_l[w_bit_idx] : r_hold_r[w_bit_idx];

  // Free-running frame counter, codec reset release and receive arming.
  // Arming happens only when a whole left half begins with the codec already
  // out of reset, so the first presented frame is always complete.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= c_cnt_reset;
      r_rstn  <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_cnt <= r_cnt + 10'd1;
      if (r_cnt == c_cnt_max)
        r_rstn <= 1'b1;
      if ((r_cnt == c_cnt_arm) && r_rstn)
        r_armed <= 1'b1;
    end
  end

  // Receive path: shift on SCLK rise events and publish both channels at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_l   <= 16'h0000;
      r_sh_r   <= 16'h0000;
      r_lft_in <= 16'h0000;
      r_rht_in <= 16'h0000;
      r_valid  <= 1'b0;
    end else begin
      if (w_rise && w_rx_slot) begin
        if (r_cnt[9])
          r_sh_l <= {r_sh_l[14:0], SDin};
        else
          r_sh_r <= {r_sh_r[14:0], SDin};
      end
      r_valid <= 1'b0;
      if ((r_cnt == c_cnt_last_rx) && r_armed) begin
        // The last right bit is being shifted this cycle; fold it in directly.
        r_valid  <= 1'b1;
        r_lft_in <= r_sh_l;
        r_rht_in <= {r_sh_r[14:0], SDin};
      end
    end
  end

  // Transmit path: capture core samples on valid, launch bits on SCLK falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_l <= 16'h0000;
      r_hold_r <= 16'h0000;
      r_sdout  <= 1'b0;
    end else begin
      if (r_valid) begin
        r_hold_l <= core.lft_out;
        r_hold_r <= core.rht_out;
      end
      if (w_fall)
        r_sdout <= w_tx_slot ? w_tx_bit : 1'b0;
    end
  end

  assign LRCLK       = r_cnt[9];
  assign SCLK        = r_cnt[3];
  assign MCLK        = r_cnt[1];
  assign RSTn        = r_rstn;
  assign SDout       = r_sdout;
  assign core.lft_in = r_lft_in;
  assign core.rht_in = r_rht_in;
  assign core.valid  = r_valid;

endmodule
`default_nettype wire

// File: doc/codec_intf.md
CODEC_INTF -- requirements
Module: codec_intf

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-002 SHALL have ports: SDin  in  1  serial ADC data from codec; SDout  out  1  serial DAC data to codec.
REQ-003 SHALL have ports: LRCLK  out  1  frame clock, 1 = left half-frame; SCLK  out  1  bit clock; MCLK  out  1  master clock; RSTn  out  1  codec reset, active-low.
REQ-004 SHALL have ports: lft_in, rht_in  out  16 each  deserialized samples to equalizer core; valid  out  1  new-sample pulse to core.
REQ-005 SHALL have ports: lft_out, rht_out  in  16 each  processed samples from equalizer core, to be serialized.

Function
REQ-006 SHALL contain a 10-bit free-running counter cnt, incrementing every clk and wrapping 0x3FF->0x000.
REQ-007 SHALL drive LRCLK=cnt[9], SCLK=cnt[3], MCLK=cnt[1], all registered with no glitches; frame = 1024 clk, SCLK = clk/16, MCLK = clk/4.
REQ-008 SHALL define bit slot b=cnt[8:4] (0..31) within each half-frame, with rise event at cnt[3:0]==4'h7 and fall event at cnt[3:0]==4'hF.
REQ-009 SHALL use I2S format: 1-bit delay after each LRCLK edge, MSB first, 16 data bits per channel, slots 17..31 don't-care.
REQ-010 SHALL shift SDin into the left shift register on rise events with cnt[9]=1 and b in 1..16, and into the right shift register on the same condition with cnt[9]=0.
REQ-011 SHALL ignore SDin on all other rise events and in all non-event cycles.
REQ-012 SHALL load lft_in and rht_in from the shift registers simultaneously in the cycle after cnt==0x107 (last right bit), and assert valid for exactly that one cycle (cnt==0x108).
REQ-013 SHALL hold lft_in and rht_in stable for the remaining 1023 clk until the next update.
REQ-014 SHALL capture lft_out and rht_out into transmit holding registers in the cycle valid is high.
REQ-015 SHALL change SDout only on fall events: left half b=0..15 drives left holding bits [15..0], right half b=0..15 drives right holding bits [15..0], all other falls drive 0.
REQ-016 SHALL make the first post-capture transmission begin at cnt==0x20F (left, b=0).
REQ-017 SHALL drive SDout=0 for any half-frame beginning before the first valid after reset.
REQ-018 SHALL let a change on lft_out or rht_out outside the valid cycle have no effect on the frame being transmitted.
REQ-019 SHALL drive RSTn low from reset until cnt first reaches 0x3FF, then high from the next clk, and keep it high until rst_n asserts again.
REQ-020 SHALL produce no valid pulse until a full left and right half-frame have been received after RSTn goes high; the first valid occurs at cnt==0x108 of the second frame after reset.
REQ-021 SHALL be 100% synchronous to clk apart from rst_n, and SHALL treat SDin as synchronous to SCLK without additional synchronizer.

Reset
REQ-022 SHALL, on rst_n low at any time including mid-frame, immediately set cnt=0x200 (LRCLK=1, SCLK=0, MCLK=0), RSTn=0, SDout=0, valid=0, and lft_in=rht_in=0.
REQ-023 SHALL, on rst_n low, clear all shift and holding registers to 0.
REQ-024 SHALL, on rst_n deassertion, resume counting from 0x200, with no partial frame data ever reaching lft_in/rht_in.

Verification
REQ-025 Clocks: release reset, run 4096 clk -> LRCLK period 1024 at 50% duty, SCLK period 16, MCLK period 4; RSTn rises exactly 512 clk after reset release.
REQ-026 Receive: codec model drives left=0xA5C3, right=0x1234 in I2S on SDin -> valid one cycle at cnt==0x108 with lft_in=0xA5C3, rht_in=0x1234; valid count = 1 per 1024 clk.
REQ-027 Transmit: hold lft_out=0x8001, rht_out=0x7FFE across valid -> next frame SDout sampled on SCLK rises, slots 1..16, yields left 0x8001, right 0x7FFE; SDout=0 in slots 17..31.
REQ-028 Isolation: change lft_out to 0xFFFF 10 clk after valid -> transmitted left word remains the captured value.
REQ-029 Mid-frame reset: assert rst_n at cnt==0x2A5 for 3 clk -> all outputs at reset values that cycle; no valid until a full new frame completes; then data correct.
REQ-030 Extremes: loopback of SDout to SDin with lft_out/rht_out=0x0000 then 0xFFFF -> lft_in/rht_in equal the values transmitted one frame earlier.
